// File: rtl/microcode_sequencer_if.sv
// Opcode handshake and bootstrap byte-write bus for the microcode sequencer.
// The master side is the instruction source / loader; the slave side is the sequencer.
interface microcode_sequencer_if #(
    parameter int OPCODE_W = 6,
    parameter int ADDR_W   = 11
);
    logic [OPCODE_W-1:0] opcode;
    logic                opcode_valid;
    logic                opcode_ready;
    logic [ADDR_W-1:0]   bootstrap_addr;
    logic [7:0]          bootstrap_data;
    logic                bootstrap_we;

    modport master (
        output opcode, opcode_valid, bootstrap_addr, bootstrap_data, bootstrap_we,
        input  opcode_ready
    );

    modport slave (
        input  opcode, opcode_valid, bootstrap_addr, bootstrap_data, bootstrap_we,
        output opcode_ready
    );
endinterface

// File: rtl/microcode_sequencer.sv
// Microcode sequencer: byte-loaded control store, then per-opcode step sequencing
// with registered control word and active-low one-hot plane selects.
module microcode_sequencer #(
    parameter int OPCODE_W = 6,
    parameter int STEP_W   = 3,
    parameter int CTRL_W   = 32,
    localparam int LANE_W  = $clog2(CTRL_W / 8),
    localparam int ADDR_W  = OPCODE_W + STEP_W + LANE_W
) (
    input  logic                  clk,
    input  logic                  rst,
    microcode_sequencer_if.slave  bus,
    input  logic                  booted,
    output logic [CTRL_W-1:0]     control,
    output logic [STEP_W-1:0]     step,
    output logic [6:0]            control_n_in,
    output logic [6:0]            control_n_out,
    output logic                  err_late_write,
    output logic                  err_overrun
);
    localparam int WORD_W = OPCODE_W + STEP_W;
    localparam int DEPTH  = 2 ** WORD_W;
    localparam logic [STEP_W-1:0] STEP_ONE = 1;
    localparam logic [STEP_W-1:0] STEP_MAX = '1;

    typedef enum logic [1:0] {BOOT, FETCH, EXEC} state_t;

    state_t              state_q, state_d;
    logic [CTRL_W-1:0]   mem [DEPTH];
    logic [OPCODE_W-1:0] op_q, op_d;
    logic [CTRL_W-1:0]   control_d;
    logic [STEP_W-1:0]   step_d;
    logic                overrun_set;
    logic [WORD_W-1:0]   word_sel;
    logic [LANE_W:0]     lane_idx;
    logic [2:0]          in_code;
    logic [2:0]          out_code;

    assign word_sel = bus.bootstrap_addr[ADDR_W-1 -: WORD_W];

    generate
        if (LANE_W > 0) begin : g_lanes
            assign lane_idx = {1'b0, bus.bootstrap_addr[LANE_W-1:0]};
        end else begin : g_single_lane
            assign lane_idx = '0;
        end
    endgenerate

    // The store has no reset so microcode survives rst; loads are only legal before boot.
    always_ff @(posedge clk) begin
        if (bus.bootstrap_we && !booted) begin
            mem[word_sel][{lane_idx, 3'b000} +: 8] <= bus.bootstrap_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= BOOT;
            op_q           <= '0;
            control        <= '0;
            step           <= '0;
            err_late_write <= 1'b0;
            err_overrun    <= 1'b0;
        end else begin
            state_q        <= state_d;
            op_q           <= op_d;
            control        <= control_d;
            step           <= step_d;
            err_late_write <= err_late_write | (bus.bootstrap_we & booted);
            err_overrun    <= err_overrun | overrun_set;
        end
    end

    // Losing booted overrides every state and abandons any instruction in flight.
    always_comb begin
        state_d          = state_q;
        op_d             = op_q;
        control_d        = control;
        step_d           = step;
        overrun_set      = 1'b0;
        bus.opcode_ready = 1'b0;
        if (!booted) begin
            state_d   = BOOT;
            control_d = '0;
            step_d    = '0;
        end else begin
            case (state_q)
                BOOT: begin
                    state_d = FETCH;
                end
                FETCH: begin
                    bus.opcode_ready = 1'b1;
                    if (bus.opcode_valid) begin
                        op_d      = bus.opcode;
                        control_d = mem[{bus.opcode, {STEP_W{1'b0}}}];
                        step_d    = '0;
                        state_d   = EXEC;
                    end
                end
                EXEC: begin
                    if (control[0] || step == STEP_MAX) begin
                        overrun_set = ~control[0];
                        control_d   = '0;
                        step_d      = '0;
                        state_d     = FETCH;
                    end else begin
                        step_d    = step + STEP_ONE;
                        control_d = mem[{op_q, step + STEP_ONE}];
                    end
                end
                default: begin
                    state_d   = BOOT;
                    control_d = '0;
                    step_d    = '0;
                end
            endcase
        end
    end

    assign in_code  = control[CTRL_W-1 -: 3];
    assign out_code = control[CTRL_W-4 -: 3];

    always_comb begin
        control_n_in  = 7'h7F;
        control_n_out = 7'h7F;
        for (int k = 0; k < 7; k++) begin
            control_n_in[k]  = !((state_q == EXEC) && (in_code == 3'(k + 1)));
            control_n_out[k] = !((state_q == EXEC) && (out_code == 3'(k + 1)));
        end
    end
endmodule
